sl_receiver_sync: RTL and testbench

Clocked, parametrised receiver for the two-wire SL serial line (sl0/sl1 return-to-idle signalling). It replaces line-edge-clocked reception with synchronised, oversampled, glitch-filtered decoding on the system clock. Word length is programmable up to DATA_W_MAX, and parity is checked. Received words are handed to the bus-bridge side through a one-entry valid/ready output register, with error pulses for parity, length, protocol, timeout and overrun.

---
 rtl/sl_receiver_sync_if.sv | 24 ++
 rtl/sl_receiver_sync.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_sl_receiver_sync.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sl_receiver_sync_if.sv
// Output side of the SL receiver: one-entry word register handed to the
// bus bridge with a valid/ready handshake.
interface sl_receiver_sync_if #(
    parameter int DATA_W_MAX = 32
);
    logic [DATA_W_MAX-1:0] out_data;
    logic                  out_perr;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_perr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_perr,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sl_receiver_sync.sv
// SL two-wire serial receiver: synchronised, glitch-filtered, oversampled
// decoding of sl0/sl1 with programmable word length and odd parity check.
module sl_receiver_sync #(
    parameter int DATA_W_MAX  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sl0,
    input  logic               sl1,
    input  logic [5:0]         word_len,
    sl_receiver_sync_if.master out_if,
    output logic               err_len,
    output logic               err_proto,
    output logic               err_timeout,
    output logic               err_overrun
);

    localparam int FCNT_W = $clog2(FILT_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        EV_NONE,
        EV_BIT0,
        EV_BIT1,
        EV_STOP,
        EV_PROTO
    } ev_e;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_e;

    // Odd parity over data plus parity bit: error when the total is even.
    function automatic logic odd_parity_err(input logic [DATA_W_MAX-1:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

    logic [SYNC_STAGES-1:0] sync0_r;
    logic [SYNC_STAGES-1:0] sync1_r;
    logic [1:0]             line_s;
    logic [1:0]             run_val_r;
    logic [FCNT_W-1:0]      run_cnt_r;
    logic [FCNT_W-1:0]      run_cnt_nxt_s;
    logic [1:0]             filt_r;
    logic [1:0]             filt_d_r;
    ev_e                    ev_s;
    logic                   bit_s;

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic                   start_s;
    logic                   take_bit_s;
    logic                   done_s;
    logic                   len_bad_s;
    logic                   proto_s;
    logic                   tmo_hit_s;
    logic                   load_s;
    logic                   ovr_s;
    logic [5:0]             eff_len_s;

    logic [5:0]             n_r;
    logic [5:0]             cnt_r;
    logic [DATA_W_MAX-1:0]  shift_r;
    logic                   par_r;
    logic [TMO_W-1:0]       tmo_r;

    logic [DATA_W_MAX-1:0]  out_data_r;
    logic                   out_perr_r;
    logic                   out_valid_r;
    logic                   err_len_r;
    logic                   err_proto_r;
    logic                   err_timeout_r;
    logic                   err_overrun_r;

    // Synchroniser chains; idle line level is high on both wires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_r <= '1;
            sync1_r <= '1;
        end else begin
            sync0_r <= {sync0_r[SYNC_STAGES-2:0], sl0};
            sync1_r <= {sync1_r[SYNC_STAGES-2:0], sl1};
        end
    end

    assign line_s = {sync0_r[SYNC_STAGES-1], sync1_r[SYNC_STAGES-1]};

    // Run-length of the current synchronised line value, saturating at FILT_LEN.
    always_comb begin
        run_cnt_nxt_s = FCNT_W'(1);
        if (line_s == run_val_r) begin
            if (run_cnt_r >= FCNT_W'(FILT_LEN)) begin
                run_cnt_nxt_s = run_cnt_r;
            end else begin
                run_cnt_nxt_s = run_cnt_r + FCNT_W'(1);
            end
        end else begin
            run_cnt_nxt_s = FCNT_W'(1);
        end
    end

    // Glitch filter: accept a line state once it has been seen FILT_LEN times in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_val_r <= 2'b11;
            run_cnt_r <= '0;
            filt_r    <= 2'b11;
            filt_d_r  <= 2'b11;
        end else begin
            run_val_r <= line_s;
            run_cnt_r <= run_cnt_nxt_s;
            filt_d_r  <= filt_r;
            if (run_cnt_nxt_s >= FCNT_W'(FILT_LEN)) begin
                filt_r <= line_s;
            end
        end
    end

    // Event decode on filtered transitions; a return to 11 carries no event.
    always_comb begin
        ev_s = EV_NONE;
        if (filt_r != filt_d_r) begin
            case (filt_r)
                2'b00: ev_s = EV_STOP;
                2'b01: begin
                    if (filt_d_r == 2'b11) begin
                        ev_s = EV_BIT0;
                    end else if (filt_d_r == 2'b10) begin
                        ev_s = EV_PROTO;
                    end else begin
                        ev_s = EV_NONE;
                    end
                end
                2'b10: begin
                    if (filt_d_r == 2'b11) begin
                        ev_s = EV_BIT1;
                    end else if (filt_d_r == 2'b01) begin
                        ev_s = EV_PROTO;
                    end else begin
                        ev_s = EV_NONE;
                    end
                end
                default: ev_s = EV_NONE;
            endcase
        end else begin
            ev_s = EV_NONE;
        end
    end

    assign bit_s     = (ev_s == EV_BIT1);
    assign eff_len_s = ((word_len == 6'd0) || (word_len > 6'(DATA_W_MAX))) ? 6'(DATA_W_MAX) : word_len;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and strobes; STOP/PROTO in IDLE are silently ignored.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        take_bit_s  = 1'b0;
        done_s      = 1'b0;
        len_bad_s   = 1'b0;
        proto_s     = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((ev_s == EV_BIT0) || (ev_s == EV_BIT1)) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                case (ev_s)
                    EV_BIT0, EV_BIT1: take_bit_s = 1'b1;
                    EV_STOP: begin
                        if (cnt_r == (n_r + 6'd1)) begin
                            done_s = 1'b1;
                        end else begin
                            len_bad_s = 1'b1;
                        end
                        state_nxt_s = ST_IDLE;
                    end
                    EV_PROTO: begin
                        proto_s     = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                    default: begin
                        if (tmo_r == TMO_W'(TIMEOUT_CYC - 1)) begin
                            tmo_hit_s   = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            tmo_hit_s   = 1'b0;
                        end
                    end
                endcase
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Word assembly: data bits go LSB-first, the bit after N data bits is parity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_r     <= '0;
            cnt_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
            tmo_r   <= '0;
        end else begin
            if (start_s) begin
                n_r     <= eff_len_s;
                shift_r <= DATA_W_MAX'(bit_s);
                par_r   <= 1'b0;
                cnt_r   <= 6'd1;
            end else if (take_bit_s) begin
                if (cnt_r < n_r) begin
                    shift_r <= shift_r | (DATA_W_MAX'(bit_s) << cnt_r);
                end else if (cnt_r == n_r) begin
                    par_r <= bit_s;
                end
                if (cnt_r < (n_r + 6'd2)) begin
                    cnt_r <= cnt_r + 6'd1;
                end
            end
            if (start_s || take_bit_s || (state_r == ST_IDLE)) begin
                tmo_r <= '0;
            end else begin
                tmo_r <= tmo_r + TMO_W'(1);
            end
        end
    end

    // A completed word is either loaded into the output slot or dropped as overrun.
    always_comb begin
        load_s = 1'b0;
        ovr_s  = 1'b0;
        if (done_s) begin
            if (!out_valid_r || out_if.out_ready) begin
                load_s = 1'b1;
            end else begin
                ovr_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
            ovr_s  = 1'b0;
        end
    end

    // Output slot and error pulses; a new load wins over a same-cycle transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r    <= '0;
            out_perr_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            err_len_r     <= 1'b0;
            err_proto_r   <= 1'b0;
            err_timeout_r <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                out_data_r  <= shift_r;
                out_perr_r  <= odd_parity_err(shift_r, par_r);
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_if.out_ready) begin
                out_valid_r <= 1'b0;
            end
            err_len_r     <= len_bad_s;
            err_proto_r   <= proto_s;
            err_timeout_r <= tmo_hit_s;
            err_overrun_r <= ovr_s;
        end
    end

    assign out_if.out_data  = out_data_r;
    assign out_if.out_perr  = out_perr_r;
    assign out_if.out_valid = out_valid_r;
    assign err_len          = err_len_r;
    assign err_proto        = err_proto_r;
    assign err_timeout      = err_timeout_r;
    assign err_overrun      = err_overrun_r;

endmodule

// File: tb/tb_sl_receiver_sync.sv
// Randomised bench for sl_receiver_sync: drives SL pulse trains and compares
// delivered words and error pulses with a word-level reference model.
module tb_sl_receiver_sync;
    localparam int DW  = 32;
    localparam int SS  = 2;
    localparam int FL  = 3;
    localparam int TMO = 4096;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sl0 = 1'b1;
    logic       sl1 = 1'b1;
    logic [5:0] word_len = 6'd8;
    logic       err_len, err_proto, err_timeout, err_overrun;

    sl_receiver_sync_if #(.DATA_W_MAX(DW)) bus ();

    sl_receiver_sync #(
        .DATA_W_MAX (DW),
        .SYNC_STAGES(SS),
        .FILT_LEN   (FL),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sl0        (sl0),
        .sl1        (sl1),
        .word_len   (word_len),
        .out_if     (bus.master),
        .err_len    (err_len),
        .err_proto  (err_proto),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cnt_len = 0, cnt_proto = 0, cnt_tmo = 0, cnt_ovr = 0;
    logic [DW:0] got_q[$];

    // Monitor: count error pulses and record every handshake transfer.
    always @(negedge clk) begin
        if (err_len)     cnt_len++;
        if (err_proto)   cnt_proto++;
        if (err_timeout) cnt_tmo++;
        if (err_overrun) cnt_ovr++;
        if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_perr, bus.out_data});
    end

    // Reference: first nbits of the stream are data (LSB first), par closes the word.
    function automatic logic [DW:0] model_word(input logic [63:0] bits, input int nbits, input logic par);
        logic [DW-1:0] d;
        int ones;
        d = '0;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            d[i] = bits[i];
            ones += int'(bits[i]);
        end
        ones += int'(par);
        return {((ones % 2) == 0), d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        sl0 = a;
        sl1 = b;
        tick(n);
    endtask

    task automatic send_bit(input logic b);
        drive(b, ~b, $urandom_range(FL, FL + 3));
        drive(1'b1, 1'b1, $urandom_range(FL, FL + 3));
    endtask

    task automatic send_stop();
        drive(1'b0, 1'b0, $urandom_range(FL, FL + 3));
        drive(1'b1, 1'b1, FL + SS + 10);
    endtask

    task automatic send_seq(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
        send_stop();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        n_total++;
        if ({bus.out_valid, bus.out_perr, bus.out_data} !== '0)
            $display("FAIL reset_out got=%h exp=0", {bus.out_valid, bus.out_perr, bus.out_data});
        else n_pass++;
        n_total++;
        if ({err_len, err_proto, err_timeout, err_overrun} !== 4'b0000)
            $display("FAIL reset_err got=%b exp=0000", {err_len, err_proto, err_timeout, err_overrun});
        else n_pass++;
        reset_n = 1'b1;
        tick(SS + FL + 4);
        n_total++;
        if ((cnt_len + cnt_proto + cnt_tmo + cnt_ovr) != 0 || bus.out_valid !== 1'b0)
            $display("FAIL reset_release errs=%0d valid=%b exp 0/0", cnt_len + cnt_proto + cnt_tmo + cnt_ovr, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [DW:0] exp;
        got_q.delete();
        bus.out_ready = 1'b0;
        word_len = 6'd8;
        exp = model_word(64'h04D, 8, 1'b0);
        send_seq(64'h04D, 9);
        n_total++;
        if (bus.out_valid !== 1'b1 || {bus.out_perr, bus.out_data} !== exp)
            $display("FAIL basic_word got=%b/%h exp=1/%h", bus.out_valid, {bus.out_perr, bus.out_data}, exp);
        else n_pass++;
        tick(20);
        n_total++;
        if (bus.out_valid !== 1'b1 || {bus.out_perr, bus.out_data} !== exp)
            $display("FAIL basic_hold got=%b/%h exp=1/%h", bus.out_valid, {bus.out_perr, bus.out_data}, exp);
        else n_pass++;
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        tick(2);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== exp || bus.out_valid !== 1'b0)
            $display("FAIL basic_xfer got n=%0d valid=%b exp n=1 valid=0", got_q.size(), bus.out_valid);
        else n_pass++;
        got_q.delete();
        bus.out_ready = 1'b1;
        exp = model_word(64'h14D, 8, 1'b1);
        send_seq(64'h14D, 9);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== exp)
            $display("FAIL basic_perr got n=%0d exp n=1 word=%h", got_q.size(), exp);
        else n_pass++;
    endtask

    task automatic test_len_err();
        int base;
        got_q.delete();
        bus.out_ready = 1'b1;
        word_len = 6'd16;
        base = cnt_len;
        send_seq({$urandom(), $urandom()}, 10);
        n_total++;
        if (cnt_len != base + 1 || got_q.size() != 0 || bus.out_valid !== 1'b0)
            $display("FAIL len_short got err=%0d words=%0d exp err=%0d words=0", cnt_len, got_q.size(), base + 1);
        else n_pass++;
        send_seq({$urandom(), $urandom()}, 18);
        n_total++;
        if (cnt_len != base + 2 || got_q.size() != 0)
            $display("FAIL len_long got err=%0d words=%0d exp err=%0d words=0", cnt_len, got_q.size(), base + 2);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int base;
        logic [DW:0] exp;
        got_q.delete();
        bus.out_ready = 1'b0;
        word_len = 6'd8;
        base = cnt_ovr;
        exp = model_word(64'h112, 8, 1'b1);
        send_seq(64'h112, 9);
        send_seq(64'h034, 9);
        n_total++;
        if (cnt_ovr != base + 1 || bus.out_valid !== 1'b1 || {bus.out_perr, bus.out_data} !== exp)
            $display("FAIL overrun_drop got ovr=%0d word=%h exp ovr=%0d word=%h", cnt_ovr, {bus.out_perr, bus.out_data}, base + 1, exp);
        else n_pass++;
        bus.out_ready = 1'b1;
        tick(6);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== exp || bus.out_valid !== 1'b0)
            $display("FAIL overrun_deliver got n=%0d valid=%b exp n=1 valid=0", got_q.size(), bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [63:0] bits;
        int base;
        got_q.delete();
        bus.out_ready = 1'b1;
        word_len = 6'd8;
        base = cnt_len + cnt_proto + cnt_tmo;
        drive(1'b0, 1'b1, 1);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, FL - 1);
        drive(1'b1, 1'b1, 10);
        bits = {$urandom(), $urandom()};
        send_seq(bits, 9);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== model_word(bits, 8, bits[8]) || (cnt_len + cnt_proto + cnt_tmo) != base)
            $display("FAIL glitch got n=%0d errs=%0d exp n=1 errs=%0d", got_q.size(), cnt_len + cnt_proto + cnt_tmo, base);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int base_t, base_l;
        logic [63:0] bits;
        got_q.delete();
        word_len = 6'd8;
        base_t = cnt_tmo;
        base_l = cnt_len;
        send_bit(1'b1);
        tick(TMO - 50);
        n_total++;
        if (cnt_tmo != base_t)
            $display("FAIL timeout_early got=%0d exp=%0d", cnt_tmo, base_t);
        else n_pass++;
        tick(80);
        n_total++;
        if (cnt_tmo != base_t + 1)
            $display("FAIL timeout_fire got=%0d exp=%0d", cnt_tmo, base_t + 1);
        else n_pass++;
        send_stop();
        n_total++;
        if (cnt_len != base_l || got_q.size() != 0)
            $display("FAIL timeout_stop got err_len=%0d words=%0d exp %0d/0", cnt_len, got_q.size(), base_l);
        else n_pass++;
        bits = {$urandom(), $urandom()};
        send_seq(bits, 9);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== model_word(bits, 8, bits[8]))
            $display("FAIL timeout_recover got n=%0d exp n=1", got_q.size());
        else n_pass++;
    endtask

    task automatic test_proto();
        int base;
        got_q.delete();
        base = cnt_proto;
        send_bit(1'b0);
        drive(1'b0, 1'b1, FL + 1);
        drive(1'b1, 1'b0, FL + 1);
        drive(1'b1, 1'b1, 10);
        send_stop();
        n_total++;
        if (cnt_proto != base + 1 || got_q.size() != 0)
            $display("FAIL proto got err=%0d words=%0d exp err=%0d words=0", cnt_proto, got_q.size(), base + 1);
        else n_pass++;
    endtask

    task automatic test_full32();
        logic [63:0] bits;
        logic [DW:0] exp;
        got_q.delete();
        word_len = 6'd32;
        bits = 64'h1_FFFF_FFFF;
        exp = model_word(bits, 32, 1'b1);
        send_seq(bits, 33);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== exp)
            $display("FAIL full32 got n=%0d exp n=1 word=%h", got_q.size(), exp);
        else n_pass++;
        got_q.delete();
        word_len = 6'd0;
        bits = {$urandom(), $urandom()};
        send_seq(bits, 33);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== model_word(bits, 32, bits[32]))
            $display("FAIL len0_as_max got n=%0d exp n=1", got_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] bits;
        int wl, n, nb, base;
        bit bad;
        bus.out_ready = 1'b1;
        for (int it = 0; it < 12; it++) begin
            got_q.delete();
            wl = $urandom_range(0, 40);
            n = (wl == 0 || wl > DW) ? DW : wl;
            bad = ($urandom_range(0, 3) == 0);
            nb = bad ? $urandom_range(1, n + 3) : n + 1;
            if (nb == n + 1) nb = n + 2;
            if (!bad) nb = n + 1;
            bits = {$urandom(), $urandom()};
            word_len = 6'(wl);
            base = cnt_len;
            for (int i = 0; i < nb; i++) begin
                send_bit(bits[i]);
                if (i == 1) word_len = 6'($urandom_range(0, 63));
            end
            send_stop();
            n_total++;
            if (bad) begin
                if (cnt_len != base + 1 || got_q.size() != 0)
                    $display("FAIL rand_len it=%0d got err=%0d words=%0d exp err=%0d words=0", it, cnt_len, got_q.size(), base + 1);
                else n_pass++;
            end else begin
                if (got_q.size() != 1 || got_q[0] !== model_word(bits, n, bits[n]) || cnt_len != base)
                    $display("FAIL rand_word it=%0d n=%0d got cnt=%0d word=%h exp %h", it, n, got_q.size(),
                             (got_q.size() > 0) ? got_q[0] : '0, model_word(bits, n, bits[n]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [63:0] bits;
        got_q.delete();
        bus.out_ready = 1'b0;
        word_len = 6'd8;
        send_seq(64'h0A5, 9);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        base = cnt_len + cnt_proto + cnt_tmo + cnt_ovr;
        #2 reset_n = 1'b0;
        tick(1);
        n_total++;
        if ({bus.out_valid, bus.out_perr, bus.out_data, err_len, err_proto, err_timeout, err_overrun} !== '0)
            $display("FAIL reset_mid_out got valid=%b data=%h exp all 0", bus.out_valid, bus.out_data);
        else n_pass++;
        tick(2);
        reset_n = 1'b1;
        tick(SS + FL + 6);
        n_total++;
        if ((cnt_len + cnt_proto + cnt_tmo + cnt_ovr) != base || got_q.size() != 0)
            $display("FAIL reset_mid_err got errs=%0d words=%0d exp %0d/0", cnt_len + cnt_proto + cnt_tmo + cnt_ovr, got_q.size(), base);
        else n_pass++;
        bus.out_ready = 1'b1;
        bits = {$urandom(), $urandom()};
        send_seq(bits, 9);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== model_word(bits, 8, bits[8]))
            $display("FAIL reset_mid_recover got n=%0d exp n=1", got_q.size());
        else n_pass++;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_err();
        test_overrun();
        test_glitch();
        test_timeout();
        test_proto();
        test_full32();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog run exceeded time limit passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
